// File: rtl/uart_rx_stream_pkg.sv
// rtl/uart_rx_stream_pkg.sv - shared state encodings, parity codes and vote helper for the UART receiver
package uart_rx_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_DELIVER = 3'd5,
        ST_BRKWAIT = 3'd6
    } rx_state_t;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam int   MIN_PRESCALE = 8;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_stream_vote_sampler.sv
// rtl/uart_rx_stream_vote_sampler.sv - three-sample majority vote with per-bit decision strobe
// Ports: clk, reset_n (sync, active low); active (frame in progress); edge_cnt/half (position
// within bit and half the bit period); rx_in (serial line); bit_val (voted level); strobe
// (one cycle per bit, when bit_val is valid).
module uart_rx_vote_sampler
    import uart_rx_stream_pkg::*;
#(
    parameter int Prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      active,
    input  logic [Prescale_width-1:0] edge_cnt,
    input  logic [Prescale_width-1:0] half,
    input  logic                      rx_in,
    output logic                      bit_val,
    output logic                      strobe
);

    logic [2:0]                taps;
    logic [Prescale_width-1:0] first_pt;
    logic [Prescale_width-1:0] decide_pt;

    assign first_pt  = half - Prescale_width'(2);
    assign decide_pt = half + Prescale_width'(1);

    // Taps are rewritten at three consecutive points every bit, so stale
    // contents from the previous bit never reach a decision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            taps <= 3'b000;
        end else if (active && edge_cnt >= first_pt && edge_cnt <= half) begin
            taps <= {taps[1:0], rx_in};
        end
    end

    assign strobe  = active && (edge_cnt == decide_pt);
    assign bit_val = majority3(taps);

endmodule

// File: rtl/uart_rx_stream.sv
// rtl/uart_rx_stream.sv - oversampled UART receiver delivering words on a valid/ready stream
// Ports: clk, reset_n (sync, active low); Prescale, DATA_LEN, PAR_EN, PAR_TYP, STP_TWO (frame
// config, latched at start bit); RX_IN (synchronised serial line); P_DATA, par_err, stp_err, brk,
// data_valid / data_ready (output word handshake); overrun (sticky drop flag), ovr_clr (clears it).
module uart_rx_stream
    import uart_rx_stream_pkg::*;
#(
    parameter int Prescale_width = 6,
    parameter int DATA_width     = 9,
    parameter int n_bits         = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [Prescale_width-1:0] Prescale,
    input  logic [n_bits-1:0]         DATA_LEN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STP_TWO,
    input  logic                      RX_IN,
    output logic [DATA_width-1:0]     P_DATA,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      brk,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      overrun,
    input  logic                      ovr_clr
);

    rx_state_t                 state;
    logic [Prescale_width-1:0] edge_cnt;
    logic [n_bits-1:0]         bit_cnt;
    logic [Prescale_width-1:0] cfg_p;
    logic [n_bits-1:0]         cfg_len;
    logic                      cfg_par_en;
    logic                      cfg_par_typ;
    logic                      cfg_stp_two;
    logic [DATA_width-1:0]     shreg;
    logic                      xor_acc;
    logic                      par_err_c;
    logic                      stp_err_c;
    logic                      zero_c;

    logic [Prescale_width-1:0] eff_p;
    logic [n_bits-1:0]         eff_len;
    logic [Prescale_width-1:0] half;
    logic                      active;
    logic                      last_edge;
    logic                      bit_val;
    logic                      strobe;
    logic                      exp_par;

    assign eff_p   = (Prescale < Prescale_width'(MIN_PRESCALE)) ? Prescale_width'(MIN_PRESCALE) : Prescale;
    assign eff_len = (DATA_LEN < n_bits'(5) || DATA_LEN > n_bits'(DATA_width)) ? n_bits'(DATA_width) : DATA_LEN;
    assign half    = cfg_p >> 1;
    assign active  = (state == ST_START) || (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
    assign last_edge = (edge_cnt == cfg_p - Prescale_width'(1));
    assign exp_par = xor_acc ^ (cfg_par_typ == PAR_ODD);

    uart_rx_vote_sampler #(.Prescale_width(Prescale_width)) u_sampler (
        .clk      (clk),
        .reset_n  (reset_n),
        .active   (active),
        .edge_cnt (edge_cnt),
        .half     (half),
        .rx_in    (RX_IN),
        .bit_val  (bit_val),
        .strobe   (strobe)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            cfg_p       <= '0;
            cfg_len     <= '0;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= 1'b0;
            cfg_stp_two <= 1'b0;
            shreg       <= '0;
            xor_acc     <= 1'b0;
            par_err_c   <= 1'b0;
            stp_err_c   <= 1'b0;
            zero_c      <= 1'b0;
            P_DATA      <= '0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            brk         <= 1'b0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // A load in DELIVER below overrides this handshake drop.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (active) begin
                edge_cnt <= last_edge ? '0 : edge_cnt + Prescale_width'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (!RX_IN) begin
                        state       <= ST_START;
                        edge_cnt    <= '0;
                        bit_cnt     <= '0;
                        cfg_p       <= eff_p;
                        cfg_len     <= eff_len;
                        cfg_par_en  <= PAR_EN;
                        cfg_par_typ <= PAR_TYP;
                        cfg_stp_two <= STP_TWO;
                        shreg       <= '0;
                        xor_acc     <= 1'b0;
                        par_err_c   <= 1'b0;
                        stp_err_c   <= 1'b0;
                        zero_c      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (strobe && bit_val) begin
                        state    <= ST_IDLE;
                        edge_cnt <= '0;
                    end else if (last_edge) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        for (int i = 0; i < DATA_width; i++) begin
                            if (n_bits'(i) == bit_cnt) begin
                                shreg[i] <= bit_val;
                            end
                        end
                        xor_acc <= xor_acc ^ bit_val;
                        if (bit_val) begin
                            zero_c <= 1'b0;
                        end
                    end
                    if (last_edge) begin
                        if (bit_cnt == cfg_len - n_bits'(1)) begin
                            bit_cnt <= '0;
                            state   <= cfg_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + n_bits'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (strobe) begin
                        par_err_c <= (bit_val != exp_par);
                        if (bit_val) begin
                            zero_c <= 1'b0;
                        end
                    end
                    if (last_edge) begin
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (strobe) begin
                        if (!bit_val) begin
                            stp_err_c <= 1'b1;
                        end else begin
                            zero_c <= 1'b0;
                        end
                        // Deliver on the last stop decision rather than the end of the bit,
                        // so the next start edge can be caught immediately.
                        if (bit_cnt == (cfg_stp_two ? n_bits'(1) : n_bits'(0))) begin
                            state    <= ST_DELIVER;
                            edge_cnt <= '0;
                        end
                    end else if (last_edge) begin
                        bit_cnt <= bit_cnt + n_bits'(1);
                    end
                end
                ST_DELIVER: begin
                    if (!data_valid || data_ready) begin
                        P_DATA     <= shreg;
                        par_err    <= par_err_c;
                        stp_err    <= stp_err_c;
                        brk        <= zero_c;
                        data_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    // A line still low here is a break; wait for it to recover
                    // instead of treating it as a new start bit.
                    state <= RX_IN ? ST_IDLE : ST_BRKWAIT;
                end
                ST_BRKWAIT: begin
                    if (RX_IN) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb/tb_uart_rx_stream.sv - self-checking bench for uart_rx_stream
module tb_uart_rx_stream;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] Prescale;
    logic [3:0] DATA_LEN;
    logic       PAR_EN, PAR_TYP, STP_TWO, RX_IN;
    logic [8:0] P_DATA;
    logic       par_err, stp_err, brk, data_valid, data_ready, overrun, ovr_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [11:0] obs_q[$];

    uart_rx_stream dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Prescale   (Prescale),
        .DATA_LEN   (DATA_LEN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STP_TWO    (STP_TWO),
        .RX_IN      (RX_IN),
        .P_DATA     (P_DATA),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .brk        (brk),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    // Record every accepted word as {brk, stp_err, par_err, P_DATA}.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && data_valid === 1'b1 && data_ready === 1'b1)
            obs_q.push_back({brk, stp_err, par_err, P_DATA});
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: what a receiver must report for a frame with these intended fields.
    function automatic logic [11:0] model_word(input logic [8:0] data, input int len, input bit par_en,
                                               input bit par_typ, input bit stp_two, input bit bad_par,
                                               input bit stop_bad);
        int         el;
        logic [9:0] m;
        logic [8:0] d;
        logic       pbit, pe, se, bk;
        el   = (len < 5 || len > 9) ? 9 : len;
        m    = (10'd1 << el) - 10'd1;
        d    = data & m[8:0];
        pbit = (^d) ^ par_typ ^ bad_par;
        pe   = par_en && bad_par;
        se   = stop_bad;
        bk   = (d == 9'd0) && (!par_en || !pbit) && stop_bad && !stp_two;
        return {bk, se, pe, d};
    endfunction

    task automatic tick_sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_level(input logic lvl, input int n);
        RX_IN = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic lvl, input int p, input bit spike);
        int s;
        if (spike) begin
            s = $urandom_range(0, p - 1);
            drive_level(lvl, s);
            drive_level(~lvl, 1);
            drive_level(lvl, p - s - 1);
        end else begin
            drive_level(lvl, p);
        end
    endtask

    task automatic send_frame(input int pres, input int len, input logic [8:0] data, input bit par_en,
                              input bit par_typ, input bit stp_two, input bit bad_par, input bit stop_bad,
                              input bit spikes, input bit scramble);
        int         ep, el;
        logic [9:0] m;
        logic [8:0] d;
        logic       pbit;
        ep   = (pres < 8) ? 8 : pres;
        el   = (len < 5 || len > 9) ? 9 : len;
        m    = (10'd1 << el) - 10'd1;
        d    = data & m[8:0];
        pbit = (^d) ^ par_typ ^ bad_par;
        Prescale = 6'(pres);
        DATA_LEN = 4'(len);
        PAR_EN   = par_en;
        PAR_TYP  = par_typ;
        STP_TWO  = stp_two;
        drive_level(1'b0, ep);
        if (scramble) begin
            Prescale = 6'($urandom);
            DATA_LEN = 4'($urandom);
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
            STP_TWO  = 1'($urandom);
        end
        for (int i = 0; i < el; i++) drive_bit(d[i], ep, spikes);
        if (par_en) drive_bit(pbit, ep, 1'b0);
        drive_level(~stop_bad, ep);
        if (stp_two) drive_level(1'b1, ep);
        drive_level(1'b1, 2 * ep);
    endtask

    task automatic wait_word(output logic [11:0] w, output bit ok);
        ok = 1'b0;
        w  = '0;
        for (int i = 0; i < 4000; i++) begin
            if (obs_q.size() > 0) begin
                w  = obs_q.pop_front();
                ok = 1'b1;
                break;
            end
            tick_sync();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        RX_IN   = 1'b1;
        repeat (3) tick_sync();
        reset_n = 1'b1;
        tick_sync();
        obs_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (P_DATA !== 9'd0) begin n_fail++; $display("FAIL reset_p_data: got %h expected 000", P_DATA); end
        n_cmp++; if ({par_err, stp_err, brk} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {par_err, stp_err, brk}); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_basic();
        logic [11:0] w;
        bit          ok;
        data_ready = 1'b1;
        send_frame(8, 8, 9'h0A5, 0, 0, 0, 0, 0, 0, 0);
        wait_word(w, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no word expected 0a5"); end
        n_cmp++; if (w !== 12'h0A5) begin n_fail++; $display("FAIL basic_word: got %h expected 0a5", w); end
        repeat (20) tick_sync();
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL basic_single_pulse: got %0d extra words expected 0", obs_q.size()); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b expected 0", data_valid); end
    endtask

    task automatic test_parity();
        logic [11:0] w;
        bit          ok;
        send_frame(16, 7, 9'h053, 1, 0, 1, 1, 0, 0, 0);
        wait_word(w, ok);
        n_cmp++; if (!ok || w[8:0] !== 9'h053) begin n_fail++; $display("FAIL parity_data: got %h expected 053", w[8:0]); end
        n_cmp++; if (w[11:9] !== 3'b001) begin n_fail++; $display("FAIL parity_flags: got %b expected 001", w[11:9]); end
    endtask

    task automatic test_glitch();
        logic [11:0] w;
        bit          ok;
        Prescale = 6'd16;
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        STP_TWO  = 1'b0;
        drive_level(1'b0, 3);
        drive_level(1'b1, 16 * 12);
        n_cmp++; if (obs_q.size() != 0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_no_word: got %0d words valid=%b expected 0", obs_q.size(), data_valid); end
        send_frame(16, 8, 9'h03C, 0, 0, 0, 0, 0, 0, 0);
        wait_word(w, ok);
        n_cmp++; if (!ok || w !== 12'h03C) begin n_fail++; $display("FAIL glitch_recover: got %h expected 03c", w); end
    endtask

    task automatic test_spikes();
        logic [11:0] w;
        bit          ok;
        send_frame(16, 8, 9'h000, 0, 0, 0, 0, 0, 1, 0);
        wait_word(w, ok);
        n_cmp++; if (!ok || w !== 12'h000) begin n_fail++; $display("FAIL spike_vote: got %h expected 000", w); end
    endtask

    task automatic test_overrun();
        logic [11:0] w;
        bit          ok;
        data_ready = 1'b0;
        send_frame(8, 8, 9'h011, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (data_valid !== 1'b1 || P_DATA !== 9'h011) begin n_fail++; $display("FAIL ovr_first_held: got valid=%b data=%h expected 1/011", data_valid, P_DATA); end
        send_frame(8, 8, 9'h022, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (P_DATA !== 9'h011) begin n_fail++; $display("FAIL ovr_old_kept: got %h expected 011", P_DATA); end
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        ovr_clr = 1'b1;
        tick_sync();
        ovr_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        data_ready = 1'b1;
        wait_word(w, ok);
        n_cmp++; if (!ok || w !== 12'h011) begin n_fail++; $display("FAIL ovr_drain: got %h expected 011", w); end
        repeat (10) tick_sync();
        n_cmp++; if (obs_q.size() != 0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_no_second: got %0d words valid=%b expected 0", obs_q.size(), data_valid); end
    endtask

    task automatic test_break();
        logic [11:0] w;
        bit          ok;
        Prescale = 6'd8;
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        STP_TWO  = 1'b0;
        drive_level(1'b0, 8 * 20);
        drive_level(1'b1, 8 * 4);
        wait_word(w, ok);
        n_cmp++; if (!ok || w[8:0] !== 9'h000) begin n_fail++; $display("FAIL break_data: got %h expected 000", w[8:0]); end
        n_cmp++; if (w[11:9] !== 3'b110) begin n_fail++; $display("FAIL break_flags: got %b expected 110", w[11:9]); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL break_single: got %0d extra words expected 0", obs_q.size()); end
        send_frame(8, 8, 9'h0F0, 0, 0, 0, 0, 0, 0, 0);
        wait_word(w, ok);
        n_cmp++; if (!ok || w !== 12'h0F0) begin n_fail++; $display("FAIL break_recover: got %h expected 0f0", w); end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] w;
        bit          ok;
        Prescale = 6'd8;
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        STP_TWO  = 1'b0;
        drive_level(1'b0, 8 * 3);
        reset_n = 1'b0;
        drive_level(1'b1, 2);
        reset_n = 1'b1;
        drive_level(1'b1, 8 * 15);
        n_cmp++; if (obs_q.size() != 0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_word: got %0d words valid=%b expected 0", obs_q.size(), data_valid); end
        send_frame(8, 6, 9'h02D, 0, 0, 0, 0, 0, 0, 0);
        wait_word(w, ok);
        n_cmp++; if (!ok || w !== 12'h02D) begin n_fail++; $display("FAIL midreset_recover: got %h expected 02d", w); end
    endtask

    task automatic test_random();
        logic [11:0] w, exp_w;
        bit          ok;
        int          pres, len;
        logic [8:0]  data;
        bit          pe, pt, s2, bp, sb;
        for (int k = 0; k < 24; k++) begin
            pres = $urandom_range(4, 24);
            len  = $urandom_range(3, 11);
            data = 9'($urandom);
            if ($urandom_range(0, 5) == 0) data = 9'd0;
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            s2   = 1'($urandom);
            bp   = pe && ($urandom_range(0, 2) == 0);
            sb   = ($urandom_range(0, 4) == 0);
            exp_w = model_word(data, len, pe, pt, s2, bp, sb);
            send_frame(pres, len, data, pe, pt, s2, bp, sb, 1'($urandom), 1'b1);
            wait_word(w, ok);
            n_cmp++;
            if (!ok || w !== exp_w) begin
                n_fail++;
                $display("FAIL random_%0d: got %h expected %h (P=%0d len=%0d par=%0b/%0b stp2=%0b)", k, w, exp_w, pres, len, pe, pt, s2);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        Prescale   = 6'd8;
        DATA_LEN   = 4'd8;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STP_TWO    = 1'b0;
        RX_IN      = 1'b1;
        data_ready = 1'b1;
        ovr_clr    = 1'b0;
        tick_sync();
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_spikes();
        test_overrun();
        test_break();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
